// File: rtl/noisy_tone_gen.sv
// +--------------------------------------------------------------------------+
// | noisy_tone_gen : DDS sine tone plus Galois-LFSR noise, saturating 16-bit  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module noisy_tone_gen #(
  parameter int          PHASE_W     = 32,
  parameter int          TONE_SHIFT  = 1,
  parameter int          NOISE_SHIFT = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               noise_en,
  output logic signed [15:0] noisy_signal,
  output logic               sample_valid
);

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64
  localparam logic [15:0] QTAB [0:64] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [PHASE_W-1:0] phase;
  logic [15:0]        lfsr;
  logic signed [15:0] tone1;
  logic signed [15:0] noise1;
  logic               v1;

  logic [7:0]         idx;
  logic [6:0]         qidx;
  logic signed [15:0] qmag;
  logic signed [15:0] lut_val;
  logic signed [15:0] tone_val;
  logic signed [15:0] noise_val;
  logic [15:0]        lfsr_next;
  logic signed [16:0] sum17;
  logic signed [15:0] sat_val;

  // Full wave rebuilt from the quarter table by mirror (odd quadrants) and negation (lower half)
  always_comb begin
    idx       = phase[PHASE_W-1 -: 8];
    qidx      = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    qmag      = $signed(QTAB[qidx]);
    lut_val   = idx[7] ? -qmag : qmag;
    tone_val  = lut_val >>> TONE_SHIFT;
    noise_val = noise_en ? ($signed(lfsr) >>> NOISE_SHIFT) : 16'sd0;
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  end

  always_comb begin
    sum17 = {tone1[15], tone1} + {noise1[15], noise1};
    if (sum17 > 17'sd32767) begin
      sat_val = 16'sh7FFF;
    end else if (sum17 < -17'sd32768) begin
      sat_val = 16'sh8000;
    end else begin
      sat_val = sum17[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      lfsr         <= LFSR_SEED;
      tone1        <= '0;
      noise1       <= '0;
      v1           <= 1'b0;
      noisy_signal <= '0;
      sample_valid <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        tone1  <= tone_val;
        noise1 <= noise_val;
        lfsr   <= lfsr_next;
      end
      // Clear wins over the increment; the sample captured above still used the old phase
      if (phase_clr) begin
        phase <= '0;
      end else if (en) begin
        phase <= phase + fcw;
      end
      sample_valid <= v1;
      if (v1) begin
        noisy_signal <= sat_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noisy_tone_gen.sv
// +--------------------------------------------------------------------------+
// | tb_noisy_tone_gen : directed checks of noisy_tone_gen (two parameter sets)|
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_noisy_tone_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               phase_clr;
  logic [31:0]        fcw;
  logic               noise_en;
  logic signed [15:0] sig_a, sig_b;
  logic               val_a, val_b;
  int                 checks = 0;
  int                 failures = 0;

  always #5 clk = ~clk;

  // a: no attenuation (exercises saturation), b: default shifts
  noisy_tone_gen #(.PHASE_W(32), .TONE_SHIFT(0), .NOISE_SHIFT(0), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .fcw(fcw),
    .noise_en(noise_en), .noisy_signal(sig_a), .sample_valid(val_a)
  );

  noisy_tone_gen dut_b (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .fcw(fcw),
    .noise_en(noise_en), .noisy_signal(sig_b), .sample_valid(val_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int exp_a, input int exp_b, input logic exp_v);
    chk({tag, "_sig_a"}, 32'(sig_a), exp_a);
    chk({tag, "_sig_b"}, 32'(sig_b), exp_b);
    chk({tag, "_val_a"}, {31'd0, val_a}, {31'd0, exp_v});
    chk({tag, "_val_b"}, {31'd0, val_b}, {31'd0, exp_v});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; phase_clr = 1'b0; fcw = 32'hC0000000; noise_en = 1'b1;

    // Reset held with en high: nothing emerges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 0, 0, 1'b0);
    end

    // Saturation / LFSR sequence, first strobe two edges after release
    rst = 1'b0;
    tick(); chk_out("sat_lat", 0, 0, 1'b0);
    tick(); chk_out("sat_s0", -21279, -5320, 1'b1);
    tick(); chk_out("sat_s1", -32768, -18276, 1'b1);
    tick(); chk_out("sat_s2", 28984, 7246, 1'b1);
    tick(); chk_out("sat_s3", 32767, 20006, 1'b1);

    // Mid-stream reset: in-flight samples are dropped, sequence restarts
    rst = 1'b1;
    tick(); chk_out("mid_rst", 0, 0, 1'b0);
    rst = 1'b0;
    tick(); chk_out("mid_drop", 0, 0, 1'b0);
    tick(); chk_out("mid_s0", -21279, -5320, 1'b1);

    // en gaps 1,0,0,1: two strobes, second equals gapless sample 1
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick(); chk_out("gap_e1", 0, 0, 1'b0);
    en = 1'b0;
    tick(); chk_out("gap_s0", -21279, -5320, 1'b1);
    tick(); chk_out("gap_hold0", -21279, -5320, 1'b0);
    en = 1'b1;
    tick(); chk_out("gap_hold1", -21279, -5320, 1'b0);
    en = 1'b0;
    tick(); chk_out("gap_s1", -32768, -18276, 1'b1);
    tick(); chk_out("gap_hold2", -32768, -18276, 1'b0);

    // Pure tone, one LUT step per sample, through the index wrap
    rst = 1'b1; fcw = 32'h01000000; noise_en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    for (int n = 0; n < 258; n++) begin
      tick();
      chk("tone_valid", {31'd0, val_a}, 32'd1);
      case (n)
        0, 128, 256: chk_out("tone_zero", 0, 0, 1'b1);
        1, 257:      chk_out("tone_1", 804, 402, 1'b1);
        2:           chk_out("tone_2", 1608, 804, 1'b1);
        64:          chk_out("tone_64", 32767, 16383, 1'b1);
        192:         chk_out("tone_192", -32767, -16384, 1'b1);
        default:     ;
      endcase
    end

    // phase_clr with en high at sample 10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      phase_clr = (k == 10);
      tick();
      case (k - 1)
        10:      chk_out("clr_s10", 7962, 3981, 1'b1);
        11:      chk_out("clr_s11", 0, 0, 1'b1);
        12:      chk_out("clr_s12", 804, 402, 1'b1);
        default: ;
      endcase
    end
    phase_clr = 1'b0;

    // phase_clr with noise on: LFSR sequence is unaffected by the clear
    rst = 1'b1; fcw = 32'hC0000000; noise_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      phase_clr = (k == 1);
      tick();
      case (k - 1)
        0:       chk_out("nclr_s0", -21279, -5320, 1'b1);
        1:       chk_out("nclr_s1", -32768, -18276, 1'b1);
        2:       chk_out("nclr_s2", 28984, 7246, 1'b1);
        3:       chk_out("nclr_s3", -18275, -12761, 1'b1);
        default: ;
      endcase
    end
    phase_clr = 1'b0;
    en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
